// File: rtl/or10_wb_switch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | or10_wb_switch_pkg                                                         |
// | Address map and target index encoding shared by the OR10 Wishbone switch.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package or10_wb_switch_pkg;

  localparam logic [7:0] c_addr_sram = 8'h00;
  localparam logic [7:0] c_addr_eth  = 8'h92;
  localparam logic [7:0] c_addr_uart = 8'h90;

  localparam int c_num_tgt  = 3;
  localparam int c_tgt_sram = 0;
  localparam int c_tgt_eth  = 1;
  localparam int c_tgt_uart = 2;

endpackage
`default_nettype wire

// File: rtl/or10_wb_addr_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | or10_wb_addr_decoder                                                       |
// | Combinational top-byte decode to a one-hot target select plus unmapped.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module or10_wb_addr_decoder
  import or10_wb_switch_pkg::*;
#(
  parameter logic [7:0] ADDR_SRAM = c_addr_sram,
  parameter logic [7:0] ADDR_ETH  = c_addr_eth,
  parameter logic [7:0] ADDR_UART = c_addr_uart
) (
  input  logic [7:0]           adr_hi,
  input  logic                 stb,
  output logic [c_num_tgt-1:0] sel,
  output logic                 unmapped
);

  always_comb begin
    sel             = '0;
    sel[c_tgt_sram] = (adr_hi == ADDR_SRAM);
    sel[c_tgt_eth]  = (adr_hi == ADDR_ETH);
    sel[c_tgt_uart] = (adr_hi == ADDR_UART);
    // Only a live strobe to a hole in the map counts as an error.
    unmapped        = stb & ~(|sel);
  end

endmodule
`default_nettype wire

// File: rtl/or10_wb_switch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | or10_wb_switch                                                             |
// | 2-initiator / 3-target Wishbone classic switch: round-robin arbitration,   |
// | top-byte decode, unmapped error response and a stalled-access watchdog.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module or10_wb_switch
  import or10_wb_switch_pkg::*;
#(
  parameter logic [7:0]  ADDR_SRAM      = c_addr_sram,
  parameter logic [7:0]  ADDR_ETH       = c_addr_eth,
  parameter logic [7:0]  ADDR_UART      = c_addr_uart,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        m0_wb_cyc_i,
  input  logic        m0_wb_stb_i,
  input  logic        m0_wb_we_i,
  input  logic [31:0] m0_wb_adr_i,
  input  logic [31:0] m0_wb_dat_i,
  input  logic [3:0]  m0_wb_sel_i,
  output logic [31:0] m0_wb_dat_o,
  output logic        m0_wb_ack_o,
  output logic        m0_wb_err_o,
  input  logic        m1_wb_cyc_i,
  input  logic        m1_wb_stb_i,
  input  logic        m1_wb_we_i,
  input  logic [31:0] m1_wb_adr_i,
  input  logic [31:0] m1_wb_dat_i,
  input  logic [3:0]  m1_wb_sel_i,
  output logic [31:0] m1_wb_dat_o,
  output logic        m1_wb_ack_o,
  output logic        m1_wb_err_o,
  output logic        t0_wb_cyc_o,
  output logic        t0_wb_stb_o,
  output logic        t0_wb_we_o,
  output logic [31:0] t0_wb_adr_o,
  output logic [31:0] t0_wb_dat_o,
  output logic [3:0]  t0_wb_sel_o,
  input  logic [31:0] t0_wb_dat_i,
  input  logic        t0_wb_ack_i,
  input  logic        t0_wb_err_i,
  output logic        t1_wb_cyc_o,
  output logic        t1_wb_stb_o,
  output logic        t1_wb_we_o,
  output logic [31:0] t1_wb_adr_o,
  output logic [31:0] t1_wb_dat_o,
  output logic [3:0]  t1_wb_sel_o,
  input  logic [31:0] t1_wb_dat_i,
  input  logic        t1_wb_ack_i,
  input  logic        t1_wb_err_i,
  output logic        t2_wb_cyc_o,
  output logic        t2_wb_stb_o,
  output logic        t2_wb_we_o,
  output logic [31:0] t2_wb_adr_o,
  output logic [31:0] t2_wb_dat_o,
  output logic [3:0]  t2_wb_sel_o,
  input  logic [31:0] t2_wb_dat_i,
  input  logic        t2_wb_ack_i,
  input  logic        t2_wb_err_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_TOUT = 2'd2
  } state_t;

  localparam logic [15:0] c_tout_last =
    16'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic        r_owner;
  logic        r_last_grant;
  logic [15:0] r_wdog;

  logic        w_cyc, w_stb, w_we;
  logic [31:0] w_adr, w_dat;
  logic [3:0]  w_sel;

  assign w_cyc = r_owner ? m1_wb_cyc_i : m0_wb_cyc_i;
  assign w_stb = r_owner ? m1_wb_stb_i : m0_wb_stb_i;
  assign w_we  = r_owner ? m1_wb_we_i  : m0_wb_we_i;
  assign w_adr = r_owner ? m1_wb_adr_i : m0_wb_adr_i;
  assign w_dat = r_owner ? m1_wb_dat_i : m0_wb_dat_i;
  assign w_sel = r_owner ? m1_wb_sel_i : m0_wb_sel_i;

  logic [c_num_tgt-1:0] w_dec_sel;
  logic                 w_unmapped;

  or10_wb_addr_decoder #(
    .ADDR_SRAM (ADDR_SRAM),
    .ADDR_ETH  (ADDR_ETH),
    .ADDR_UART (ADDR_UART)
  ) u_dec (
    .adr_hi   (w_adr[31:24]),
    .stb      (w_stb),
    .sel      (w_dec_sel),
    .unmapped (w_unmapped)
  );

  logic                 w_busy;
  logic [c_num_tgt-1:0] w_tgt;

  assign w_busy = (r_state == ST_BUSY);
  assign w_tgt  = (w_busy && w_cyc) ? w_dec_sel : '0;

  logic [c_num_tgt-1:0]       w_t_ack, w_t_err, w_t_stb, w_t_we;
  logic [c_num_tgt-1:0][31:0] w_t_rdat, w_t_adr, w_t_wdat;
  logic [c_num_tgt-1:0][3:0]  w_t_sel;

  assign w_t_ack[c_tgt_sram]  = t0_wb_ack_i;
  assign w_t_ack[c_tgt_eth]   = t1_wb_ack_i;
  assign w_t_ack[c_tgt_uart]  = t2_wb_ack_i;
  assign w_t_err[c_tgt_sram]  = t0_wb_err_i;
  assign w_t_err[c_tgt_eth]   = t1_wb_err_i;
  assign w_t_err[c_tgt_uart]  = t2_wb_err_i;
  assign w_t_rdat[c_tgt_sram] = t0_wb_dat_i;
  assign w_t_rdat[c_tgt_eth]  = t1_wb_dat_i;
  assign w_t_rdat[c_tgt_uart] = t2_wb_dat_i;

  for (genvar k = 0; k < c_num_tgt; k++) begin : g_tgt
    assign w_t_stb[k]  = w_tgt[k] & w_stb;
    assign w_t_we[k]   = w_tgt[k] & w_we;
    assign w_t_adr[k]  = w_tgt[k] ? w_adr : '0;
    assign w_t_wdat[k] = w_tgt[k] ? w_dat : '0;
    assign w_t_sel[k]  = w_tgt[k] ? w_sel : '0;
  end

  logic        w_ack, w_err;
  logic [31:0] w_rdat;

  // Deselected targets and the abort cycle contribute nothing (w_tgt is zero).
  always_comb begin
    w_ack  = 1'b0;
    w_err  = (w_busy & w_cyc & w_unmapped) | (r_state == ST_TOUT);
    w_rdat = '0;
    for (int k = 0; k < c_num_tgt; k++) begin
      if (w_tgt[k]) begin
        w_ack  = w_ack | w_t_ack[k];
        w_err  = w_err | w_t_err[k];
        w_rdat = w_rdat | w_t_rdat[k];
      end
    end
  end

  logic w_tout_hit;
  assign w_tout_hit = w_busy & w_cyc & w_stb & ~w_ack & ~w_err &
                      (TIMEOUT_CYCLES != 0) & (r_wdog == c_tout_last);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state      <= ST_IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_wdog       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_wdog <= '0;
          if (m0_wb_cyc_i || m1_wb_cyc_i) begin
            r_state <= ST_BUSY;
            r_owner <= (m0_wb_cyc_i && m1_wb_cyc_i) ? ~r_last_grant : m1_wb_cyc_i;
          end
        end
        ST_BUSY: begin
          if (!w_cyc) begin
            r_state      <= ST_IDLE;
            r_last_grant <= r_owner;
            r_wdog       <= '0;
          end else if (w_tout_hit) begin
            r_state <= ST_TOUT;
            r_wdog  <= '0;
          end else if (!w_stb || w_ack || w_err) begin
            r_wdog <= '0;
          end else begin
            r_wdog <= r_wdog + 16'd1;
          end
        end
        ST_TOUT: begin
          r_wdog <= '0;
          if (w_cyc) begin
            r_state <= ST_BUSY;
          end else begin
            r_state      <= ST_IDLE;
            r_last_grant <= r_owner;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m0_wb_ack_o = ~r_owner & w_ack;
  assign m0_wb_err_o = ~r_owner & w_err;
  assign m0_wb_dat_o = r_owner ? '0 : w_rdat;
  assign m1_wb_ack_o = r_owner & w_ack;
  assign m1_wb_err_o = r_owner & w_err;
  assign m1_wb_dat_o = r_owner ? w_rdat : '0;

  assign t0_wb_cyc_o = w_tgt[c_tgt_sram];
  assign t0_wb_stb_o = w_t_stb[c_tgt_sram];
  assign t0_wb_we_o  = w_t_we[c_tgt_sram];
  assign t0_wb_adr_o = w_t_adr[c_tgt_sram];
  assign t0_wb_dat_o = w_t_wdat[c_tgt_sram];
  assign t0_wb_sel_o = w_t_sel[c_tgt_sram];
  assign t1_wb_cyc_o = w_tgt[c_tgt_eth];
  assign t1_wb_stb_o = w_t_stb[c_tgt_eth];
  assign t1_wb_we_o  = w_t_we[c_tgt_eth];
  assign t1_wb_adr_o = w_t_adr[c_tgt_eth];
  assign t1_wb_dat_o = w_t_wdat[c_tgt_eth];
  assign t1_wb_sel_o = w_t_sel[c_tgt_eth];
  assign t2_wb_cyc_o = w_tgt[c_tgt_uart];
  assign t2_wb_stb_o = w_t_stb[c_tgt_uart];
  assign t2_wb_we_o  = w_t_we[c_tgt_uart];
  assign t2_wb_adr_o = w_t_adr[c_tgt_uart];
  assign t2_wb_dat_o = w_t_wdat[c_tgt_uart];
  assign t2_wb_sel_o = w_t_sel[c_tgt_uart];

endmodule
`default_nettype wire

// File: tb/tb_or10_wb_switch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_or10_wb_switch                                                          |
// | Self-checking bench: vector table, directed sequences, random + model.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_or10_wb_switch;

  localparam int TOUT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       m_cyc, m_stb, m_we;
  logic [1:0][31:0] m_adr, m_wdat;
  logic [1:0][3:0]  m_sel;
  wire  [1:0][31:0] m_rdat;
  wire  [1:0]       m_ack, m_err;

  wire  [2:0]       t_cyc, t_stb, t_we;
  wire  [2:0][31:0] t_adr, t_wdat;
  wire  [2:0][3:0]  t_sel;
  logic [2:0][31:0] t_rdat;
  logic [2:0]       t_ack, t_err;

  int n_err = 0;
  int n_checks = 0;

  or10_wb_switch #(.TIMEOUT_CYCLES(TOUT)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .m0_wb_cyc_i(m_cyc[0]), .m0_wb_stb_i(m_stb[0]), .m0_wb_we_i(m_we[0]),
    .m0_wb_adr_i(m_adr[0]), .m0_wb_dat_i(m_wdat[0]), .m0_wb_sel_i(m_sel[0]),
    .m0_wb_dat_o(m_rdat[0]), .m0_wb_ack_o(m_ack[0]), .m0_wb_err_o(m_err[0]),
    .m1_wb_cyc_i(m_cyc[1]), .m1_wb_stb_i(m_stb[1]), .m1_wb_we_i(m_we[1]),
    .m1_wb_adr_i(m_adr[1]), .m1_wb_dat_i(m_wdat[1]), .m1_wb_sel_i(m_sel[1]),
    .m1_wb_dat_o(m_rdat[1]), .m1_wb_ack_o(m_ack[1]), .m1_wb_err_o(m_err[1]),
    .t0_wb_cyc_o(t_cyc[0]), .t0_wb_stb_o(t_stb[0]), .t0_wb_we_o(t_we[0]),
    .t0_wb_adr_o(t_adr[0]), .t0_wb_dat_o(t_wdat[0]), .t0_wb_sel_o(t_sel[0]),
    .t0_wb_dat_i(t_rdat[0]), .t0_wb_ack_i(t_ack[0]), .t0_wb_err_i(t_err[0]),
    .t1_wb_cyc_o(t_cyc[1]), .t1_wb_stb_o(t_stb[1]), .t1_wb_we_o(t_we[1]),
    .t1_wb_adr_o(t_adr[1]), .t1_wb_dat_o(t_wdat[1]), .t1_wb_sel_o(t_sel[1]),
    .t1_wb_dat_i(t_rdat[1]), .t1_wb_ack_i(t_ack[1]), .t1_wb_err_i(t_err[1]),
    .t2_wb_cyc_o(t_cyc[2]), .t2_wb_stb_o(t_stb[2]), .t2_wb_we_o(t_we[2]),
    .t2_wb_adr_o(t_adr[2]), .t2_wb_dat_o(t_wdat[2]), .t2_wb_sel_o(t_sel[2]),
    .t2_wb_dat_i(t_rdat[2]), .t2_wb_ack_i(t_ack[2]), .t2_wb_err_i(t_err[2])
  );

  task automatic check(input string name, input logic [70:0] act, input logic [70:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [33:0] act_m(input int i);
    return {m_ack[i], m_err[i], m_rdat[i]};
  endfunction

  function automatic logic [70:0] act_t(input int k);
    return {t_cyc[k], t_stb[k], t_we[k], t_adr[k], t_wdat[k], t_sel[k]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_wdat = '0; m_sel = '0;
    t_ack = '0; t_err = '0; t_rdat = '0;
  endtask

  // ---------------- reference model: who holds the bus, and for how long ----
  bit  md_gnt = 0;
  bit  md_abort = 0;
  int  md_own = 0;
  int  md_last = 1;
  int  md_cnt = 0;
  logic [33:0] e_m [2];
  logic [70:0] e_t [3];

  function automatic int region(input logic [31:0] a);
    case (a[31:24])
      8'h00:   return 0;
      8'h92:   return 1;
      8'h90:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic mdl_expect(output bit resp);
    int k;
    resp = 0;
    for (int i = 0; i < 2; i++) e_m[i] = '0;
    for (int j = 0; j < 3; j++) e_t[j] = '0;
    if (!rst_n) return;
    if (md_abort) begin
      e_m[md_own] = {1'b0, 1'b1, 32'h0};
      resp = 1;
    end else if (md_gnt && m_cyc[md_own]) begin
      k = region(m_adr[md_own]);
      if (k < 3) begin
        e_t[k] = {1'b1, m_stb[md_own], m_we[md_own], m_adr[md_own], m_wdat[md_own], m_sel[md_own]};
        e_m[md_own] = {t_ack[k], t_err[k], t_rdat[k]};
        resp = t_ack[k] | t_err[k];
      end else begin
        e_m[md_own] = {1'b0, m_stb[md_own], 32'h0};
        resp = m_stb[md_own];
      end
    end
  endtask

  task automatic mdl_step(input bit resp);
    if (!rst_n) begin
      md_gnt = 0; md_abort = 0; md_own = 0; md_last = 1; md_cnt = 0;
    end else if (md_abort) begin
      md_abort = 0; md_cnt = 0;
      if (m_cyc[md_own]) md_gnt = 1;
      else md_last = md_own;
    end else if (md_gnt) begin
      if (!m_cyc[md_own]) begin
        md_gnt = 0; md_last = md_own; md_cnt = 0;
      end else if (!m_stb[md_own] || resp) begin
        md_cnt = 0;
      end else if (md_cnt + 1 >= TOUT) begin
        md_gnt = 0; md_abort = 1; md_cnt = 0;
      end else begin
        md_cnt++;
      end
    end else if (m_cyc != 2'b00) begin
      md_own = (m_cyc == 2'b11) ? 1 - md_last : (m_cyc[0] ? 0 : 1);
      md_gnt = 1;
    end
  endtask

  always @(negedge clk) begin
    bit resp;
    mdl_expect(resp);
    for (int i = 0; i < 2; i++) check($sformatf("model_m%0d", i), act_m(i), e_m[i]);
    for (int k = 0; k < 3; k++) check($sformatf("model_t%0d", k), act_t(k), e_t[k]);
    mdl_step(resp);
  end

  // ---------------- vector table: single transfers, one initiator ----------
  typedef struct {
    int          ini;
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic        ack;
    logic        err;
    logic [31:0] rdat;      // target k returns rdat + k
    int          exp_tgt;   // 3 = no target
    logic        exp_ack;
    logic        exp_err;
    logic [31:0] exp_rdat;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [31:0] rand_adr();
    case ($urandom_range(0, 3))
      0:       return {8'h00, 24'($urandom)};
      1:       return {8'h92, 24'($urandom)};
      2:       return {8'h90, 24'($urandom)};
      default: return {8'h51 + 8'($urandom_range(0, 15)), 24'($urandom)};
    endcase
  endfunction

  initial begin
    int n;
    bit seen;

    vecs[0] = '{0, 32'h0000_0010, 1'b0, 4'hF, 32'h0,         1, 0, 32'hDEAD_BEEF, 0, 1, 0, 32'hDEAD_BEEF};
    vecs[1] = '{1, 32'h9200_0004, 1'b1, 4'h3, 32'h1234_5678, 1, 0, 32'h0000_1000, 1, 1, 0, 32'h0000_1001};
    vecs[2] = '{0, 32'h5000_0000, 1'b0, 4'hF, 32'h0,         1, 0, 32'h7777_0000, 3, 0, 1, 32'h0};
    vecs[3] = '{1, 32'h9000_00FC, 1'b0, 4'h1, 32'h0,         1, 1, 32'hA5A5_0000, 2, 1, 1, 32'hA5A5_0002};
    vecs[4] = '{0, 32'h00FF_FFFC, 1'b1, 4'hC, 32'hCAFE_F00D, 0, 1, 32'h0BAD_0000, 0, 0, 1, 32'h0BAD_0000};
    vecs[5] = '{1, 32'h9100_0000, 1'b1, 4'hF, 32'h5555_AAAA, 1, 1, 32'h1111_0000, 3, 0, 1, 32'h0};

    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_m0", act_m(0), 0);
    check("reset_m1", act_m(1), 0);
    check("reset_t0", act_t(0), 0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      int o;
      o = vecs[v].ini;
      m_cyc[o] = 1; m_stb[o] = 1; m_we[o] = vecs[v].we;
      m_adr[o] = vecs[v].adr; m_wdat[o] = vecs[v].wdat; m_sel[o] = vecs[v].sel;
      @(negedge clk);
      check($sformatf("vec%0d_arb_dead", v), {t_cyc, m_ack, m_err}, 0);
      tick();
      t_ack = {3{vecs[v].ack}};
      t_err = {3{vecs[v].err}};
      for (int k = 0; k < 3; k++) t_rdat[k] = vecs[v].rdat + 32'(k);
      @(negedge clk);
      for (int k = 0; k < 3; k++)
        check($sformatf("vec%0d_t%0d", v, k), act_t(k),
              (k == vecs[v].exp_tgt) ?
              {1'b1, 1'b1, vecs[v].we, vecs[v].adr, vecs[v].wdat, vecs[v].sel} : 71'h0);
      check($sformatf("vec%0d_owner", v), act_m(o),
            {vecs[v].exp_ack, vecs[v].exp_err, vecs[v].exp_rdat});
      check($sformatf("vec%0d_other", v), act_m(1 - o), 0);
      tick();
      drive_idle();
      tick();
    end

    // Arbitration: simultaneous request, release, dead cycle, round-robin.
    m_cyc = 2'b11; m_stb = 2'b11;
    m_adr[0] = 32'h0000_0010; m_adr[1] = 32'h0000_0020;
    @(negedge clk);
    check("arb_first_dead", t_cyc, 0);
    tick();
    @(negedge clk);
    check("arb_first_m0", {t_cyc[0], t_adr[0]}, {1'b1, 32'h0000_0010});
    tick();
    m_cyc[0] = 0; m_stb[0] = 0;
    @(negedge clk);
    check("arb_release", t_cyc, 0);
    tick();
    @(negedge clk);
    check("arb_dead_waiting", t_cyc, 0);
    tick();
    @(negedge clk);
    check("arb_then_m1", {t_cyc[0], t_adr[0]}, {1'b1, 32'h0000_0020});
    tick();
    m_cyc[1] = 0; m_stb[1] = 0;
    tick();
    m_cyc = 2'b11; m_stb = 2'b11;
    tick();
    @(negedge clk);
    check("arb_rr_m0", {t_cyc[0], t_adr[0]}, {1'b1, 32'h0000_0010});
    tick();
    drive_idle();
    tick(); tick();

    // Watchdog: UART never answers.
    m_cyc[0] = 1; m_stb[0] = 1; m_adr[0] = 32'h9000_0000;
    n = 0; seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (m_err[0]) begin
        seen = 1;
        check("tout_abort_t2", {t_cyc[2], t_stb[2]}, 0);
      end else if (t_stb[2]) begin
        n++;
      end
    end
    check("tout_seen", 71'(seen), 1);
    check("tout_stb_cycles", 71'(n), TOUT);
    tick();
    drive_idle();
    tick(); tick();

    // Asynchronous reset in the middle of a pending SRAM access.
    m_cyc[0] = 1; m_stb[0] = 1; m_adr[0] = 32'h0000_0040;
    tick(); tick();
    @(negedge clk);
    check("rst_pending", t_cyc[0], 1);
    #2;
    rst_n = 1'b0;
    t_ack[0] = 1;
    #1;
    check("rst_async_t0", act_t(0), 0);
    check("rst_async_m0", act_m(0), 0);
    tick(); tick();
    rst_n = 1'b1;
    drive_idle();
    tick();
    m_cyc = 2'b11; m_stb = 2'b11;
    m_adr[0] = 32'h0000_0010; m_adr[1] = 32'h0000_0020;
    tick();
    @(negedge clk);
    check("rst_then_m0", {t_cyc[0], t_adr[0]}, {1'b1, 32'h0000_0010});
    tick();
    drive_idle();
    tick(); tick();

    // Random traffic, checked every cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 9) == 0) m_cyc[i] = ~m_cyc[i];
        m_stb[i]  = m_cyc[i] && ($urandom_range(0, 99) < 85);
        m_we[i]   = 1'($urandom);
        m_adr[i]  = rand_adr();
        m_wdat[i] = $urandom;
        m_sel[i]  = 4'($urandom);
      end
      for (int k = 0; k < 3; k++) begin
        t_ack[k]  = ($urandom_range(0, 99) < 30);
        t_err[k]  = ($urandom_range(0, 99) < 5);
        t_rdat[k] = $urandom;
      end
    end
    tick();
    drive_idle();
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
